// File: rtl/reg_dump_if.sv
// Byte-stream and register-file port bundle for reg_dump.
// master = the environment (register file + sink), slave = the dumper.
interface reg_dump_if;
    logic        start;
    logic        abort;
    logic [3:0]  r_sel;
    logic [31:0] r_value;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;

    modport master (
        output start, abort, r_value, out_ready,
        input  r_sel, out_data, out_valid, busy, done
    );

    modport slave (
        input  start, abort, r_value, out_ready,
        output r_sel, out_data, out_valid, busy, done
    );
endinterface

// File: rtl/reg_dump.sv
// Streams registers x0..x[NUM_REGS-1] LSB byte first over a valid/ready byte port.
// Define REG_DUMP_CHECKSUM_EN to append an XOR checksum byte after the last register.
module reg_dump #(
    parameter int NUM_REGS = 16
) (
    input logic       clk,
    input logic       rst,
    reg_dump_if.slave dump
);
    localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
`ifdef REG_DUMP_CHECKSUM_EN
        , CSUM = 2'd3
`endif
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  regIdx_q, regIdx_d;
    logic [1:0]  byteCnt_q, byteCnt_d;
    logic [31:0] shift_q, shift_d;
    logic        done_q, done_d;
    logic        xfer;
`ifdef REG_DUMP_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif

    assign xfer = dump.out_valid && dump.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            regIdx_q  <= 4'd0;
            byteCnt_q <= 2'd0;
            shift_q   <= 32'd0;
            done_q    <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
            csum_q    <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            regIdx_q  <= regIdx_d;
            byteCnt_q <= byteCnt_d;
            shift_q   <= shift_d;
            done_q    <= done_d;
`ifdef REG_DUMP_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        regIdx_d  = regIdx_q;
        byteCnt_d = byteCnt_q;
        shift_d   = shift_q;
        done_d    = 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
        csum_d    = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (dump.start) begin
                    state_d   = LOAD;
                    regIdx_d  = 4'd0;
                    byteCnt_d = 2'd0;
`ifdef REG_DUMP_CHECKSUM_EN
                    csum_d    = 8'd0;
`endif
                end
            end
            LOAD: begin
                shift_d = dump.r_value;
                state_d = SEND;
            end
            SEND: begin
                if (xfer) begin
                    shift_d   = {8'h00, shift_q[31:8]};
                    byteCnt_d = byteCnt_q + 2'd1;
`ifdef REG_DUMP_CHECKSUM_EN
                    csum_d    = csum_q ^ shift_q[7:0];
`endif
                    if (byteCnt_q == 2'd3) begin
                        if (regIdx_q < LAST_IDX) begin
                            regIdx_d = regIdx_q + 4'd1;
                            state_d  = LOAD;
                        end else begin
`ifdef REG_DUMP_CHECKSUM_EN
                            state_d  = CSUM;
`else
                            state_d  = IDLE;
                            regIdx_d = 4'd0;
                            done_d   = 1'b1;
`endif
                        end
                    end
                end
            end
`ifdef REG_DUMP_CHECKSUM_EN
            CSUM: begin
                if (xfer) begin
                    state_d  = IDLE;
                    regIdx_d = 4'd0;
                    done_d   = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        // Abort wins over any transfer in the same cycle and suppresses done.
        if (dump.abort && (state_q != IDLE)) begin
            state_d   = IDLE;
            regIdx_d  = 4'd0;
            byteCnt_d = 2'd0;
            done_d    = 1'b0;
        end
    end

    always_comb begin
        dump.busy      = (state_q != IDLE);
        dump.done      = done_q;
        dump.r_sel     = regIdx_q;
        dump.out_valid = 1'b0;
        dump.out_data  = 8'h00;
        case (state_q)
            SEND: begin
                dump.out_valid = !dump.abort;
                dump.out_data  = shift_q[7:0];
            end
`ifdef REG_DUMP_CHECKSUM_EN
            CSUM: begin
                dump.out_valid = !dump.abort;
                dump.out_data  = csum_q;
            end
`endif
            default: begin
                dump.out_valid = 1'b0;
                dump.out_data  = 8'h00;
            end
        endcase
    end
endmodule

// File: tb/tb_reg_dump.sv
// Bench for reg_dump: table rows, random dumps against a byte-stream model, and
// hand sequences for abort, reset, late register writes and NUM_REGS=1.
module tb_reg_dump;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    reg_dump_if bus ();
    reg_dump_if bus1 ();

    logic [31:0] regFile [16];

    assign bus.r_value  = regFile[bus.r_sel];
    assign bus1.r_value = regFile[bus1.r_sel];

    reg_dump #(.NUM_REGS(16)) dut (
        .clk  (clk),
        .rst  (rst),
        .dump (bus.slave)
    );

    reg_dump #(.NUM_REGS(1)) dut1 (
        .clk  (clk),
        .rst  (rst),
        .dump (bus1.slave)
    );

    int errCount   = 0;
    int checkCount = 0;

    logic [7:0] capQ  [$];
    logic [7:0] cap1Q [$];
    logic [7:0] expQ  [$];

    int   doneCnt     = 0;
    int   done1Cnt    = 0;
    int   cycleIdx    = 0;
    int   lastXferCyc = 0;
    int   doneCyc     = -10;
    bit   stallPrev   = 1'b0;
    logic [7:0] stallData = 8'h00;

    typedef struct {
        logic [31:0] x1;
        logic [31:0] fill;
        int          mode;
        bit          extraStarts;
        logic [63:0] expHead;
        logic [7:0]  expCsum;
    } vec_t;

    vec_t vecs [4];

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Transfers are sampled on the falling edge, when inputs and outputs are settled.
    always @(negedge clk) begin
        cycleIdx++;
        if (!rst) begin
            if (bus.out_valid && bus.out_ready) begin
                capQ.push_back(bus.out_data);
                lastXferCyc = cycleIdx;
            end
            if (bus.done) begin
                doneCnt++;
                doneCyc = cycleIdx;
            end
            if (stallPrev && bus.out_valid)
                checkOutput("stall_hold", {56'd0, bus.out_data}, {56'd0, stallData});
            stallPrev = bus.out_valid && !bus.out_ready;
            stallData = bus.out_data;
            if (bus1.out_valid && bus1.out_ready) cap1Q.push_back(bus1.out_data);
            if (bus1.done) done1Cnt++;
        end else begin
            stallPrev = 1'b0;
        end
    end

    // Reference stream: every register LSB byte first, then the XOR of all bytes when enabled.
    task automatic buildExpected(input int numRegs);
        logic [7:0] sum;
        sum = 8'h00;
        expQ.delete();
        for (int r = 0; r < numRegs; r++) begin
            for (int b = 0; b < 4; b++) begin
                expQ.push_back(8'((regFile[r] >> (8 * b)) & 32'hFF));
                sum = sum ^ 8'((regFile[r] >> (8 * b)) & 32'hFF);
            end
        end
`ifdef REG_DUMP_CHECKSUM_EN
        expQ.push_back(sum);
`endif
    endtask

    task automatic compareStream(input string tag);
        checkOutput({tag, "_count"}, 64'(capQ.size()), 64'(expQ.size()));
        for (int i = 0; i < expQ.size(); i++) begin
            checkOutput($sformatf("%s_byte%0d", tag, i),
                        (i < capQ.size()) ? {56'd0, capQ[i]} : 64'hDEAD,
                        {56'd0, expQ[i]});
        end
    endtask

    // mode 0: always ready, 1: ready pattern 1-0-0-1, 2: random ready
    task automatic applyStimulus(input string tag, input int mode, input bit extraStarts,
                                 input bit writeX2);
        int cyc;
        bit finished;
        capQ.delete();
        doneCnt = 0;
        buildExpected(16);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        cyc = 0;
        finished = 1'b0;
        while (!finished && cyc < 3000) begin
            case (mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
            if (writeX2 && bus.r_sel == 4'd2 && bus.out_valid) regFile[2] = 32'hAAAAAAAA;
            bus.start = extraStarts && bus.busy &&
                        (((cyc % 7) == 3) ||
                         ((capQ.size() == expQ.size() - 1) && bus.out_valid && bus.out_ready));
            step();
            cyc++;
            finished = (doneCnt > 0);
        end
        bus.start = 1'b0;
        if (!finished) checkOutput({tag, "_timeout"}, 64'd0, 64'd1);
        repeat (3) step();
        checkOutput({tag, "_idle_after"}, 64'(bus.busy), 64'd0);
        compareStream(tag);
        checkOutput({tag, "_done_count"}, 64'(doneCnt), 64'd1);
        checkOutput({tag, "_done_timing"}, 64'(doneCyc - lastXferCyc), 64'd1);
    endtask

    initial begin
        int cyc;
        logic [63:0] head;

        vecs[0] = '{32'h12345678, 32'h00000000, 0, 1'b0, 64'h12345678_00000000, 8'h08};
        vecs[1] = '{32'h12345678, 32'h00000000, 1, 1'b0, 64'h12345678_00000000, 8'h08};
        vecs[2] = '{32'h12345678, 32'h00000000, 2, 1'b1, 64'h12345678_00000000, 8'h08};
        vecs[3] = '{32'hDEADBEEF, 32'h01020304, 1, 1'b1, 64'hDEADBEEF_01020304, 8'h26};

        rst = 1'b1;
        bus.start = 1'b0;  bus.abort = 1'b0;  bus.out_ready = 1'b0;
        bus1.start = 1'b0; bus1.abort = 1'b0; bus1.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) regFile[i] = 32'd0;
        step();
        step();
        checkOutput("reset_busy", 64'(bus.busy), 64'd0);
        checkOutput("reset_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("reset_data", 64'(bus.out_data), 64'd0);
        checkOutput("reset_done", 64'(bus.done), 64'd0);
        checkOutput("reset_rsel", 64'(bus.r_sel), 64'd0);
        rst = 1'b0;
        step();

        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < 16; i++) regFile[i] = vecs[v].fill;
            regFile[1] = vecs[v].x1;
            applyStimulus($sformatf("vec%0d", v), vecs[v].mode, vecs[v].extraStarts, 1'b0);
            head = 64'd0;
            for (int i = 0; i < 8; i++)
                if (i < capQ.size()) head[8*i +: 8] = capQ[i];
            checkOutput($sformatf("vec%0d_head", v), head, vecs[v].expHead);
`ifdef REG_DUMP_CHECKSUM_EN
            checkOutput($sformatf("vec%0d_csum", v),
                        (capQ.size() > 64) ? {56'd0, capQ[64]} : 64'hDEAD,
                        {56'd0, vecs[v].expCsum});
`endif
        end

        // Late write to x2 must not disturb the dump that already loaded it.
        for (int i = 0; i < 16; i++) regFile[i] = 32'h11111111 * (i % 10);
        applyStimulus("late_write", 0, 1'b0, 1'b1);
        checkOutput("x2_old", (capQ.size() > 11) ? {32'd0, capQ[11], capQ[10], capQ[9], capQ[8]} : 64'hDEAD,
                    64'h22222222);
        applyStimulus("after_write", 0, 1'b0, 1'b0);
        checkOutput("x2_new", (capQ.size() > 11) ? {32'd0, capQ[11], capQ[10], capQ[9], capQ[8]} : 64'hDEAD,
                    64'hAAAAAAAA);

        // Abort while x5 is stalled in SEND.
        for (int i = 0; i < 16; i++) regFile[i] = 32'h03030303 * (i + 1);
        capQ.delete();
        doneCnt = 0;
        bus.out_ready = 1'b1;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        cyc = 0;
        while (capQ.size() < 20 && cyc < 500) begin step(); cyc++; end
        bus.out_ready = 1'b0;
        cyc = 0;
        while (!(bus.out_valid && bus.r_sel == 4'd5) && cyc < 50) begin step(); cyc++; end
        checkOutput("abort_at_x5", 64'(bus.r_sel), 64'd5);
        step();
        bus.abort = 1'b1;
        #2;
        checkOutput("abort_valid_drop", 64'(bus.out_valid), 64'd0);
        step();
        bus.abort = 1'b0;
        checkOutput("abort_busy", 64'(bus.busy), 64'd0);
        checkOutput("abort_valid", 64'(bus.out_valid), 64'd0);
        repeat (3) step();
        checkOutput("abort_no_done", 64'(doneCnt), 64'd0);
        checkOutput("abort_bytes", 64'(capQ.size()), 64'd20);
        applyStimulus("post_abort", 0, 1'b0, 1'b0);

        // Reset between clock edges while a byte is stalled.
        for (int i = 0; i < 16; i++) regFile[i] = 32'h5A5A5A5A;
        bus.out_ready = 1'b0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        checkOutput("pre_reset_valid", 64'(bus.out_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("mid_reset_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("mid_reset_data", 64'(bus.out_data), 64'd0);
        checkOutput("mid_reset_busy", 64'(bus.busy), 64'd0);
        checkOutput("mid_reset_rsel", 64'(bus.r_sel), 64'd0);
        step();
        rst = 1'b0;
        step();
        step();
        checkOutput("post_reset_busy", 64'(bus.busy), 64'd0);
        applyStimulus("post_reset", 2, 1'b0, 1'b0);

        // Single-register instance.
        regFile[0] = 32'hCAFEF00D;
        cap1Q.delete();
        done1Cnt = 0;
        bus1.out_ready = 1'b1;
        bus1.start = 1'b1;
        step();
        bus1.start = 1'b0;
        repeat (15) step();
        buildExpected(1);
        checkOutput("one_count", 64'(cap1Q.size()), 64'(expQ.size()));
        checkOutput("one_bytes", (cap1Q.size() > 3) ? {32'd0, cap1Q[3], cap1Q[2], cap1Q[1], cap1Q[0]} : 64'hDEAD,
                    64'hCAFEF00D);
        checkOutput("one_done", 64'(done1Cnt), 64'd1);

        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < 16; i++) regFile[i] = $urandom;
            applyStimulus($sformatf("rand%0d", n), 2, 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end
endmodule
